spi_slave_gen: RTL and testbench

Parametrised SPI slave front-end for the memory-mapped SPI subsystem, sampled directly on the system clock. It decodes write, read-address and read-data frames of configurable payload width and hands completed frames to the RAM wrapper on `rx_data`/`rx_valid`. Read data from the RAM is accepted on `tx_data`/`tx_valid` and shifted out on MISO. Compared with the fixed 8-bit slave, it adds:
- frame buffering, so `rx_data` is updated only on a complete frame;
- single-cycle `rx_valid` pulses;
- abort detection and a read-response timeout;
- a selectable bit order.

---
 rtl/spi_slave_gen.sv | 130 +++++++++++++
 tb/tb_spi_slave_gen.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_gen.sv
// SPI slave front-end sampled on the system clock: decodes write / read-address /
// read-data frames, hands completed frames to the RAM side and shifts read data out on MISO.
module spi_slave_gen #(
   parameter int DATA_W    = 8,
   parameter int TIMEOUT   = 255,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic [DATA_W+1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              frame_err,
   output logic              busy
);
   localparam int FRAME_W = DATA_W + 2;
   localparam int CNT_W   = $clog2(FRAME_W + 1);
   localparam int WCNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0]  CNT_FRAME = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0]  CNT_TX    = CNT_W'(DATA_W - 1);
   localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [2:0] {
      IDLE, CHK_CMD, WRITE, RD_ADDR, RD_DATA, RD_WAIT, RD_TX, DONE
   } state_t;

   state_t              state;
   logic                addr_seen;
   logic [CNT_W-1:0]    bit_cnt;
   logic [WCNT_W-1:0]   wait_cnt;
   logic [FRAME_W-1:0]  rx_shift;
   logic [DATA_W-1:0]   tx_shift;
   logic [FRAME_W-1:0]  rx_next;

   function automatic logic [FRAME_W-1:0] shift_in(input logic [FRAME_W-1:0] sr, input logic b);
      return MSB_FIRST ? {sr[FRAME_W-2:0], b} : {b, sr[FRAME_W-1:1]};
   endfunction

   function automatic logic tx_head(input logic [DATA_W-1:0] d);
      return MSB_FIRST ? d[DATA_W-1] : d[0];
   endfunction

   function automatic logic [DATA_W-1:0] tx_advance(input logic [DATA_W-1:0] d);
      return MSB_FIRST ? (d << 1) : (d >> 1);
   endfunction

   assign rx_next = shift_in(rx_shift, MOSI);
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr_seen <= 1'b0;
         bit_cnt   <= '0;
         wait_cnt  <= '0;
         rx_shift  <= '0;
         tx_shift  <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         MISO      <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         // Deselect wins over everything; mid-frame it is an abort that leaves rx_data and addr_seen alone.
         if (SS_n) begin
            if (state != IDLE && state != DONE) frame_err <= 1'b1;
            MISO  <= 1'b0;
            state <= IDLE;
         end else begin
            case (state)
               IDLE: state <= CHK_CMD;
               CHK_CMD: begin
                  bit_cnt <= CNT_FRAME;
                  if (!MOSI)          state <= WRITE;
                  else if (addr_seen) state <= RD_DATA;
                  else                state <= RD_ADDR;
               end
               WRITE, RD_ADDR, RD_DATA: begin
                  rx_shift <= rx_next;
                  bit_cnt  <= bit_cnt - 1'b1;
                  if (bit_cnt == CNT_W'(1)) begin
                     rx_data  <= rx_next;
                     rx_valid <= 1'b1;
                     if (state == RD_DATA) begin
                        wait_cnt <= '0;
                        state    <= RD_WAIT;
                     end else begin
                        if (state == RD_ADDR) addr_seen <= 1'b1;
                        state <= DONE;
                     end
                  end
               end
               RD_WAIT: begin
                  if (tx_valid) begin
                     MISO     <= tx_head(tx_data);
                     tx_shift <= tx_advance(tx_data);
                     bit_cnt  <= CNT_TX;
                     state    <= RD_TX;
                  end else begin
                     wait_cnt <= wait_cnt + 1'b1;
                     // addr_seen is kept so the master can retry the read-data frame.
                     if (TIMEOUT != 0 && wait_cnt == WAIT_LAST) begin
                        frame_err <= 1'b1;
                        state     <= DONE;
                     end
                  end
               end
               RD_TX: begin
                  if (bit_cnt == '0) begin
                     MISO      <= 1'b0;
                     addr_seen <= 1'b0;
                     state     <= DONE;
                  end else begin
                     MISO     <= tx_head(tx_shift);
                     tx_shift <= tx_advance(tx_shift);
                     bit_cnt  <= bit_cnt - 1'b1;
                  end
               end
               DONE:    MISO  <= 1'b0;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_spi_slave_gen.sv
// Scoreboard bench for spi_slave_gen: one 8-bit MSB-first slave with a short timeout and
// one 16-bit LSB-first slave, driven by directed frames with hand-computed expectations.
module tb_spi_slave_gen;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ss_a = 1'b1, ss_b = 1'b1, mosi = 1'b0, tx_valid = 1'b0;
   logic [15:0] tx_data = '0;
   logic        miso_a, rx_valid_a, frame_err_a, busy_a;
   logic [9:0]  rx_data_a;
   logic        miso_b, rx_valid_b, frame_err_b, busy_b;
   logic [17:0] rx_data_b;
   int          cyc = 0;
   int          n_chk = 0, n_fail = 0;

   typedef struct { int kind; int cyc; logic [17:0] val; } ev_t;   // kind 0 = rx_valid, 1 = frame_err
   typedef struct { int cyc; logic b; } bit_t;
   ev_t  evq_a[$], evq_b[$];
   bit_t misoq_a[$], misoq_b[$];

   spi_slave_gen #(.DATA_W(8), .TIMEOUT(4), .MSB_FIRST(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .SS_n(ss_a), .MOSI(mosi), .MISO(miso_a),
      .rx_data(rx_data_a), .rx_valid(rx_valid_a), .tx_data(tx_data[7:0]),
      .tx_valid(tx_valid), .frame_err(frame_err_a), .busy(busy_a));

   spi_slave_gen #(.DATA_W(16), .TIMEOUT(255), .MSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .SS_n(ss_b), .MOSI(mosi), .MISO(miso_b),
      .rx_data(rx_data_b), .rx_valid(rx_valid_b), .tx_data(tx_data),
      .tx_valid(tx_valid), .frame_err(frame_err_b), .busy(busy_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops an expected event whenever the DUT pulses rx_valid or frame_err,
   // and pops an expected MISO bit on the cycles a read response is due (MISO must be 0 otherwise).
   task automatic mon(input int d, input logic rv, input logic fe, input logic [17:0] data, input logic miso);
      ev_t  e;
      bit_t m;
      int   ne, nm;
      string tag;
      tag = (d == 0) ? "a" : "b";
      ne = (d == 0) ? evq_a.size() : evq_b.size();
      if (ne > 0) begin
         if (d == 0) e = evq_a[0]; else e = evq_b[0];
         if (e.cyc < cyc) begin
            chk($sformatf("%s_missed_event_cycle", tag), cyc, e.cyc);
            if (d == 0) void'(evq_a.pop_front()); else void'(evq_b.pop_front());
            ne--;
            if (ne > 0) begin
               if (d == 0) e = evq_a[0]; else e = evq_b[0];
            end
         end
      end
      if (rv || fe) begin
         chk($sformatf("%s_rxvalid_err_exclusive", tag), {31'b0, rv & fe}, 0);
         if (ne == 0) chk($sformatf("%s_unexpected_event", tag), {30'b0, rv, fe}, 0);
         else begin
            if (d == 0) void'(evq_a.pop_front()); else void'(evq_b.pop_front());
            chk($sformatf("%s_event_kind", tag), fe ? 1 : 0, e.kind);
            chk($sformatf("%s_event_cycle", tag), cyc, e.cyc);
            if (e.kind == 0) chk($sformatf("%s_rx_data", tag), {14'b0, data}, {14'b0, e.val});
         end
      end
      nm = (d == 0) ? misoq_a.size() : misoq_b.size();
      if (nm > 0) begin
         if (d == 0) m = misoq_a[0]; else m = misoq_b[0];
      end
      if (nm > 0 && m.cyc <= cyc) begin
         if (d == 0) void'(misoq_a.pop_front()); else void'(misoq_b.pop_front());
         chk($sformatf("%s_miso_bit_cycle", tag), cyc, m.cyc);
         chk($sformatf("%s_miso_bit", tag), {31'b0, miso}, {31'b0, m.b});
      end else begin
         chk($sformatf("%s_miso_idle", tag), {31'b0, miso}, 0);
      end
   endtask

   always @(negedge clk) begin
      mon(0, rx_valid_a, frame_err_a, {8'b0, rx_data_a}, miso_a);
      mon(1, rx_valid_b, frame_err_b, rx_data_b, miso_b);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_ss(input int d, input logic v);
      if (d == 0) ss_a = v; else ss_b = v;
   endtask

   task automatic push_ev(input int d, input int kind, input int c, input logic [17:0] v);
      ev_t e;
      e.kind = kind; e.cyc = c; e.val = v;
      if (d == 0) evq_a.push_back(e); else evq_b.push_back(e);
   endtask

   task automatic push_bit(input int d, input int c, input logic b);
      bit_t m;
      m.cyc = c; m.b = b;
      if (d == 0) misoq_a.push_back(m); else misoq_b.push_back(m);
   endtask

   // An input driven at a negedge is sampled on the next posedge, so its effect shows at cyc+1.
   task automatic send(input int d, input logic sel, input logic [17:0] frame, input int fw,
                       input bit msb, input int nbits);
      set_ss(d, 1'b0);
      mosi = 1'b0;
      tick();
      mosi = sel;
      for (int i = 0; i < nbits; i++) begin
         tick();
         mosi = msb ? frame[fw-1-i] : frame[i];
      end
   endtask

   task automatic full_frame(input int d, input logic sel, input logic [17:0] frame, input int fw, input bit msb);
      send(d, sel, frame, fw, msb, fw);
      push_ev(d, 0, cyc + 1, frame);
   endtask

   task automatic end_txn(input int d);
      tick();
      set_ss(d, 1'b1);
      tick();
      tick();
   endtask

   task automatic read_tx(input int d, input logic [15:0] tx, input int dw, input bit msb);
      int et;
      tick();
      tx_data  = tx;
      tx_valid = 1'b1;
      et = cyc + 1;
      for (int k = 0; k < dw; k++) push_bit(d, et + k, msb ? tx[dw-1-k] : tx[k]);
      push_bit(d, et + dw, 1'b0);
      tick();
      tx_valid = 1'b0;
      for (int k = 0; k < dw; k++) tick();
      end_txn(d);
   endtask

   // Offers tx_valid for a while after a frame that must not have entered RD_DATA.
   task automatic hold_tx_no_response(input int d);
      tick();
      tx_valid = 1'b1;
      repeat (12) tick();
      tx_valid = 1'b0;
      end_txn(d);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      tick();
      tick();
      chk("reset_miso_a", {31'b0, miso_a}, 0);
      chk("reset_busy_a", {31'b0, busy_a}, 0);
      chk("reset_rx_data_a", {22'b0, rx_data_a}, 0);
      chk("reset_rx_valid_a", {31'b0, rx_valid_a}, 0);
      chk("reset_frame_err_a", {31'b0, frame_err_a}, 0);
      chk("reset_rx_data_b", {14'b0, rx_data_b}, 0);
      chk("reset_busy_b", {31'b0, busy_b}, 0);
      rst_n = 1'b1;
      tick();

      // Write frame 00_1010_0101.
      full_frame(0, 1'b0, 18'h0A5, 10, 1'b1);
      end_txn(0);
      chk("write_rx_data_hold", {22'b0, rx_data_a}, 32'h0A5);

      // Read-address then read-data, response 0xC3 -> 1,1,0,0,0,0,1,1.
      full_frame(0, 1'b1, 18'h230, 10, 1'b1);
      end_txn(0);
      full_frame(0, 1'b1, 18'h300, 10, 1'b1);
      read_tx(0, 16'h00C3, 8, 1'b1);

      // addr_seen cleared after the response: this select-1 frame is a read address.
      full_frame(0, 1'b1, 18'h255, 10, 1'b1);
      hold_tx_no_response(0);

      // Abort after 5 bits of a write.
      send(0, 1'b0, 18'h0F0, 10, 1'b1, 5);
      tick();
      chk("abort_busy_before", {31'b0, busy_a}, 1);
      set_ss(0, 1'b1);
      push_ev(0, 1, cyc + 1, '0);
      tick();
      chk("abort_busy_after", {31'b0, busy_a}, 0);
      chk("abort_rx_data_kept", {22'b0, rx_data_a}, 32'h255);
      tick();

      // Timeout: read-data frame, tx_valid never offered; error after 4 RD_WAIT cycles.
      full_frame(0, 1'b1, 18'h3AA, 10, 1'b1);
      push_ev(0, 1, cyc + 5, '0);
      repeat (6) tick();
      chk("timeout_busy_done", {31'b0, busy_a}, 1);
      set_ss(0, 1'b1);
      tick();
      tick();

      // Retry of the read-data frame still goes straight to RD_DATA.
      full_frame(0, 1'b1, 18'h300, 10, 1'b1);
      read_tx(0, 16'h005A, 8, 1'b1);

      // 16-bit LSB-first slave: write, read address, read data 0x8001.
      full_frame(1, 1'b0, 18'h08421, 18, 1'b0);
      end_txn(1);
      chk("b_rx_data_hold", {14'b0, rx_data_b}, 32'h08421);
      full_frame(1, 1'b1, 18'h200F0, 18, 1'b0);
      end_txn(1);
      full_frame(1, 1'b1, 18'h30000, 18, 1'b0);
      read_tx(1, 16'h8001, 16, 1'b0);

      // Asynchronous reset in the middle of a response.
      full_frame(0, 1'b1, 18'h211, 10, 1'b1);
      end_txn(0);
      full_frame(0, 1'b1, 18'h300, 10, 1'b1);
      tick();
      tx_data  = 16'h00C3;
      tx_valid = 1'b1;
      push_bit(0, cyc + 1, 1'b1);
      push_bit(0, cyc + 2, 1'b1);
      tick();
      tx_valid = 1'b0;
      tick();
      #2;
      chk("pre_reset_miso", {31'b0, miso_a}, 1);
      chk("pre_reset_busy", {31'b0, busy_a}, 1);
      rst_n = 1'b0;
      #1;
      chk("async_reset_miso", {31'b0, miso_a}, 0);
      chk("async_reset_busy", {31'b0, busy_a}, 0);
      chk("async_reset_frame_err", {31'b0, frame_err_a}, 0);
      chk("async_reset_rx_valid", {31'b0, rx_valid_a}, 0);
      chk("async_reset_rx_data", {22'b0, rx_data_a}, 0);
      tick();
      set_ss(0, 1'b1);
      rst_n = 1'b1;
      tick();
      tick();

      // addr_seen is 0 after reset: a select-1 frame is a read address again.
      full_frame(0, 1'b1, 18'h2F0, 10, 1'b1);
      hold_tx_no_response(0);

      repeat (4) tick();
      chk("evq_a_drained", evq_a.size(), 0);
      chk("evq_b_drained", evq_b.size(), 0);
      chk("misoq_a_drained", misoq_a.size(), 0);
      chk("misoq_b_drained", misoq_b.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
